uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmitter that drains the UART transmit FIFO and drives the `tx` line. It pops one byte at a time through the FIFO's read strobe and frames it with a start bit, 5–8 data bits sent LSB first, optional parity and 1 or 2 stop bits. Bit timing comes from the shared oversampling baud tick. It sits between the TX FIFO's read side and the pad.

## Interface
- `OVERSAMPLE`, default 16: `s_tick` pulses per bit period. Must be a power of two, at least 2.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `s_tick` input 1: baud tick, one-cycle pulse at OVERSAMPLE × baud rate.
- `fifo_data` input 8: head of the TX FIFO. Valid whenever `fifo_empty` = 0.
- `fifo_empty` input 1: TX FIFO empty flag.
- `fifo_rd` output 1: one-cycle pop strobe to the TX FIFO.
- `data_bits` input 2: 00 = 5 bits, 01 = 6, 10 = 7, 11 = 8.
- `parity_en` input 1: insert a parity bit.
- `parity_even` input 1: 1 = even parity, 0 = odd parity.
- `stop2` input 1: 1 = two stop bits, 0 = one.
- `set_break` input 1: force `tx` low.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: high while a frame is in progress.
- `tx_done_tick` output 1: one-cycle pulse when the last stop bit ends.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE, with `fifo_empty` = 0 and `set_break` = 0:
  - Assert `fifo_rd` for exactly one cycle.
  - In that same cycle, latch `fifo_data`, `data_bits`, `parity_en`, `parity_even` and `stop2` into frame registers.
  - Clear the tick and bit counters, then go to START.
- Config inputs are ignored mid-frame; only the latched copies are used.
- START: `tx` = 0. After OVERSAMPLE ticks, go to DATA.
- DATA:
  - `tx` = shift-register bit 0. Shift right every OVERSAMPLE ticks.
  - After N = data_bits+5 bits, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: `tx` = XOR of the N latched data bits, inverted when parity is odd. Lasts OVERSAMPLE ticks.
- STOP:
  - `tx` = 1 for OVERSAMPLE ticks, or 2×OVERSAMPLE ticks when `stop2` is set.
  - On the final tick, pulse `tx_done_tick` and go to IDLE.
- `tx_busy` = 1 in every state except IDLE.
- Break:
  - While `set_break` = 1, `tx` is 0 regardless of state.
  - The FSM keeps running through a frame already in progress.
  - No new pop is started while `set_break` is high.
- `tx` is a registered output and carries no glitches.

## Timing
- Reset values: `tx` = 1, `fifo_rd` = 0, `tx_busy` = 0, `tx_done_tick` = 0; state IDLE; counters 0.
- Reset mid-frame: on the next edge, `tx` = 1 and state is IDLE. No `fifo_rd` is issued and no `tx_done_tick` is pulsed. The partial frame is lost.
- Pop latency: `fifo_rd` rises in the cycle after `fifo_empty` is seen low in IDLE.
- Start-bit latency: `tx` falls on the edge that ends the `fifo_rd` cycle.
- Bit periods are counted in `s_tick` pulses, not clocks. The start bit ends on the OVERSAMPLE-th tick after START is entered.
- Frame length in ticks: OVERSAMPLE × (1 + N + parity_en + 1 + stop2).
- Back-to-back frames: IDLE lasts exactly 1 cycle between `tx_done_tick` and the next `fifo_rd`. There is never a second pop within one frame.
- Tick counter: log2(OVERSAMPLE) bits, wraps naturally. Bit counter: 3 bits. Stop counter: one extra bit to cover 2×OVERSAMPLE.
- When `s_tick` is held low, the state freezes and `tx` holds its value.

## Structure
- Shared package `uart_pkg` holds:
  - The state enum (IDLE/START/DATA/PARITY/STOP).
  - The `data_bits` encoding constants.
  - The default OVERSAMPLE value.
- No sub-module is needed. Parity is a masked XOR reduction inside the block.
- The baud tick comes from the existing baud generator. This block must not contain its own divider.

## Test plan
- 8N1, OVERSAMPLE = 16, FIFO holds 0x55:
  - Exactly one `fifo_rd` pulse.
  - `tx` sequence is 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks long, 160 ticks total.
  - `tx_done_tick` pulses once.
- 8E1 with 0xA5: parity bit = 0. 8O1 with 0xA5: parity bit = 1. Frame is 176 ticks.
- 5O2 with 0x1F:
  - Data bits 1,1,1,1,1, parity = 0.
  - Stop bit is high for 32 ticks; total 9 bit periods (144 ticks).
  - `data_bits` changed mid-frame does not alter the frame.
- Three bytes 0x01, 0x02, 0x03 preloaded:
  - Three `fifo_rd` pulses, one per frame.
  - Exactly 1 idle cycle between each `tx_done_tick` and the next `fifo_rd`.
  - Bytes go out in FIFO order.
- `reset` asserted during the third data bit of 0xFF:
  - Next cycle: `tx` = 1, `tx_busy` = 0, no `tx_done_tick`.
  - After reset releases with the FIFO non-empty, a new frame starts cleanly.
- `set_break` = 1 with the FIFO non-empty: `tx` = 0 and no `fifo_rd`. After release, `tx` = 1 and the pending byte is popped one cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, character-length codes
// and the default oversampling ratio.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  // Parity over the active character bits only; odd parity inverts the XOR.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] data_bits,
                                       input logic       even);
    logic [7:0] mask;
    case (data_bits)
      DATA_BITS_5: mask = 8'h1F;
      DATA_BITS_6: mask = 8'h3F;
      DATA_BITS_7: mask = 8'h7F;
      DATA_BITS_8: mask = 8'hFF;
      default:     mask = 8'hFF;
    endcase
    return (^(data & mask)) ^ ~even;
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmitter: pops bytes from the TX FIFO and frames them as
// start / 5-8 data bits LSB first / optional parity / 1-2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [1:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic       stop2,
  input  logic       set_break,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  tx_state_e     state, state_n;
  logic [CW-1:0] tick_cnt, tick_n;
  logic [2:0]    bit_cnt, bit_n;
  logic          stop_ext, stop_ext_n;
  logic [7:0]    shreg, shreg_n;

  // Frame configuration captured at pop time.
  logic [2:0]    last_bit_q;
  logic          parity_en_q;
  logic          parity_q;
  logic          stop2_q;

  logic          load;
  logic          rd_n;
  logic          done_n;
  logic          tx_n;
  logic          bit_end;

  assign bit_end = s_tick && (tick_cnt == TICK_LAST);
  assign tx_busy = (state != IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_n    = state;
    tick_n     = s_tick ? tick_cnt + 1'b1 : tick_cnt;
    bit_n      = bit_cnt;
    stop_ext_n = stop_ext;
    shreg_n    = shreg;
    load       = 1'b0;
    rd_n       = 1'b0;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        tick_n     = '0;
        bit_n      = '0;
        stop_ext_n = 1'b0;
        if (!fifo_empty && !set_break) begin
          rd_n    = 1'b1;
          load    = 1'b1;
          shreg_n = fifo_data;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == last_bit_q) state_n = parity_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        // The extra bit stretches the stop phase to a second bit period.
        if (bit_end) begin
          if (stop2_q && !stop_ext) begin
            stop_ext_n = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // The line is registered from the current state, so it trails state by one clock.
    case (state)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg[0];
      PARITY:  tx_n = parity_q;
      default: tx_n = 1'b1;
    endcase
    if (set_break) tx_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      stop_ext     <= 1'b0;
      shreg        <= '0;
      last_bit_q   <= '0;
      parity_en_q  <= 1'b0;
      parity_q     <= 1'b0;
      stop2_q      <= 1'b0;
      fifo_rd      <= 1'b0;
      tx_done_tick <= 1'b0;
      tx           <= 1'b1;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick_n;
      bit_cnt      <= bit_n;
      stop_ext     <= stop_ext_n;
      shreg        <= shreg_n;
      fifo_rd      <= rd_n;
      tx_done_tick <= done_n;
      tx           <= tx_n;
      if (load) begin
        last_bit_q  <= {1'b0, data_bits} + 3'd4;
        parity_en_q <= parity_en;
        parity_q    <= calc_parity(fifo_data, data_bits, parity_even);
        stop2_q     <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a
// monitor decodes tx at mid-bit and compares bit values and frame length.
module tb_uart_tx_engine;

  localparam int OS = 16;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [1:0] data_bits;
  logic       parity_en;
  logic       parity_even;
  logic       stop2;
  logic       set_break;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         par_en;
    bit         par;
    bit         stop2;
    int         ticks;
    bit         b2b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         stray = 0;
  bit         tick_phase = 1'b0;

  uart_tx_engine #(.OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .data_bits    (data_bits),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .stop2        (stop2),
    .set_break    (set_break),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, want);
  endtask

  // One clock of stimulus, applied at the falling edge: FIFO pop, baud tick, FIFO outputs.
  task automatic step(output bit rd, output bit tk);
    @(negedge clk);
    rd = fifo_rd;
    if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    tick_phase = ~tick_phase;
    s_tick     = tick_phase;
    tk         = tick_phase;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic idle_steps(input int n);
    bit rd, tk;
    for (int i = 0; i < n; i++) step(rd, tk);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [1:0] db, input bit pe,
                            input bit ev, input bit s2, input bit par, input int ticks,
                            input bit b2b);
    exp_t e;
    data_bits   = db;
    parity_en   = pe;
    parity_even = ev;
    stop2       = s2;
    e.data   = d;
    e.n      = int'(db) + 5;
    e.par_en = pe;
    e.par    = par;
    e.stop2  = s2;
    e.ticks  = ticks;
    e.b2b    = b2b;
    exp_q.push_back(e);
    fifo_q.push_back(d);
  endtask

  task automatic wait_done(input string name);
    bit rd, tk;
    int i;
    for (i = 0; i < 800; i++) begin
      step(rd, tk);
      if (tx_done_tick) break;
    end
    check({name, "_done_seen"}, 32'(i < 800), 1);
  endtask

  task automatic wait_pop(input string name, output bit last_tk);
    bit rd, tk;
    int i;
    tk = 1'b0;
    for (i = 0; i < 50; i++) begin
      step(rd, tk);
      if (rd) break;
    end
    last_tk = tk;
    check({name, "_pop_seen"}, 32'(i < 50), 1);
  endtask

  // Monitor: samples just after each rising edge, decodes frames started by fifo_rd.
  initial begin : monitor
    exp_t e;
    bit   in_frame;
    bit   exp_bits[$];
    int   cnt;
    int   cyc;
    int   last_done;
    int   extra_pops;
    in_frame   = 1'b0;
    cnt        = 0;
    cyc        = 0;
    last_done  = -100;
    extra_pops = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        in_frame = 1'b0;
        continue;
      end
      if (!in_frame) begin
        if (tx_done_tick) stray++;
        if (fifo_rd) begin
          check("pop_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() == 0) continue;
          e = exp_q.pop_front();
          exp_bits.delete();
          exp_bits.push_back(1'b0);
          for (int i = 0; i < e.n; i++) exp_bits.push_back(e.data[i]);
          if (e.par_en) exp_bits.push_back(e.par);
          exp_bits.push_back(1'b1);
          if (e.stop2) exp_bits.push_back(1'b1);
          if (e.b2b) check("b2b_gap", cyc - last_done, 1);
          in_frame   = 1'b1;
          cnt        = 0;
          extra_pops = 0;
        end
      end else begin
        if (fifo_rd) extra_pops++;
        if (s_tick) begin
          cnt++;
          if ((cnt % OS) == OS / 2 && (cnt / OS) < exp_bits.size()) begin
            check($sformatf("d%02h_bit%0d", e.data, cnt / OS), tx, exp_bits[cnt / OS]);
            if (cnt / OS == 0) check("busy_in_frame", tx_busy, 1);
          end
        end
        if (tx_done_tick) begin
          check($sformatf("d%02h_ticks", e.data), cnt, e.ticks);
          check("pops_in_frame", extra_pops, 0);
          check("busy_after_done", tx_busy, 0);
          last_done = cyc;
          in_frame  = 1'b0;
        end else if (cnt > e.ticks + OS) begin
          check($sformatf("d%02h_ticks_no_done", e.data), cnt, e.ticks);
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    bit rd, tk;
    int tcnt;
    reset       = 1'b1;
    s_tick      = 1'b0;
    fifo_empty  = 1'b1;
    fifo_data   = 8'h00;
    data_bits   = 2'b11;
    parity_en   = 1'b0;
    parity_even = 1'b0;
    stop2       = 1'b0;
    set_break   = 1'b0;
    idle_steps(3);
    check("rst_tx", tx, 1);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done_tick, 0);
    reset = 1'b0;
    idle_steps(4);

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    push_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b0);
    wait_done("8n1");
    // 0xA5 has four ones: even parity 0, odd parity 1
    push_frame(8'hA5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 176, 1'b0);
    wait_done("8e1");
    push_frame(8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 176, 1'b0);
    wait_done("8o1");
    // 5O2 0x1F: five ones, odd parity 0, 9 bit periods; data_bits changes mid-frame
    push_frame(8'h1F, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 144, 1'b0);
    wait_pop("5o2", tk);
    data_bits = 2'b11;
    wait_done("5o2");
    idle_steps(5);

    // Three preloaded bytes, sent back to back in FIFO order
    push_frame(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b0);
    push_frame(8'h02, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b1);
    push_frame(8'h03, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b1);
    wait_done("b2b_1");
    wait_done("b2b_2");
    wait_done("b2b_3");
    idle_steps(5);

    // Reset in the middle of the third data bit of 0xFF
    push_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b0);
    wait_pop("rst_frame", tk);
    tcnt = int'(tk);
    while (tcnt < 3 * OS + OS / 2) begin
      step(rd, tk);
      tcnt += int'(tk);
    end
    push_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b0);
    step(rd, tk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_done", tx_done_tick, 0);
    check("midrst_fifo_rd", fifo_rd, 0);
    idle_steps(2);
    reset = 1'b0;
    wait_done("after_rst");
    idle_steps(5);

    // Break holds the line low and blocks the pop until released
    set_break = 1'b1;
    push_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(rd, tk);
      if (i >= 2) begin
        check("brk_tx", tx, 0);
        check("brk_fifo_rd", fifo_rd, 0);
      end
    end
    set_break = 1'b0;
    @(posedge clk);
    #1;
    check("brk_rel_tx", tx, 1);
    check("brk_rel_fifo_rd", fifo_rd, 1);
    wait_done("brk_frame");
    idle_steps(10);

    check("stray_events", stray, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
